sat_timer_bank: RTL and testbench

Multi-channel saturating timer bank: NUM_CH independent up/down counters of WIDTH bits, each with its own programmable min and max saturation bounds, a per-channel run/done state machine and a one-cycle expiry pulse. It is the parametrised successor of the single saturation counter/timer and serves as the phase-timer core of the traffic-light controller, with one channel per signal head or pedestrian phase. All channels share one command port and one global count-enable tick.

---
 rtl/sat_timer_bank.sv | 165 ++++++++++++++++
 tb/tb_sat_timer_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_timer_bank.sv
// Purpose : bank of NUM_CH saturating up/down phase timers sharing one command port and one tick.
// Latency : command/tick effects appear on count/busy/done/expired one cycle after the sampling edge.
// Backpressure: none; one command is accepted every cycle, and a command to a channel overrides tick for that channel.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   cmd_valid/ch/op/data  command strobe, target channel (>= NUM_CH ignored),
//                         op 00 START, 01 SET_MIN, 10 SET_MAX, 11 CLEAR, operand
//   tick              global count enable for channels in RUN
//   dir               per channel: 1 counts down toward min, 0 counts up toward max
//   count             channel i at [i*WIDTH +: WIDTH]
//   busy/done         channel in RUN / DONE
//   expired           one-cycle pulse when a channel reaches its terminal bound
//
// Optional feature: define SAT_TIMER_RELOAD_EN for periodic (auto-reload) channels.
module sat_timer_bank #(
  parameter int WIDTH   = 7,
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic [CH_BITS-1:0]        cmd_ch,
  input  logic [1:0]                cmd_op,
  input  logic [WIDTH-1:0]          cmd_data,
  input  logic                      tick,
  input  logic [NUM_CH-1:0]         dir,
  output logic [NUM_CH*WIDTH-1:0]   count,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         expired
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_START   = 2'b00;
  localparam logic [1:0] OP_SET_MIN = 2'b01;
  localparam logic [1:0] OP_SET_MAX = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;

  logic [WIDTH-1:0] cnt_q [NUM_CH];
  logic [WIDTH-1:0] cnt_d [NUM_CH];
  logic [WIDTH-1:0] min_q [NUM_CH];
  logic [WIDTH-1:0] min_d [NUM_CH];
  logic [WIDTH-1:0] max_q [NUM_CH];
  logic [WIDTH-1:0] max_d [NUM_CH];
  state_t           st_q  [NUM_CH];
  state_t           st_d  [NUM_CH];
  logic [NUM_CH-1:0] exp_q;
  logic [NUM_CH-1:0] exp_d;
`ifdef SAT_TIMER_RELOAD_EN
  logic [WIDTH-1:0] rld_q [NUM_CH];
  logic [WIDTH-1:0] rld_d [NUM_CH];
`endif

  // Per-channel helpers: command decode, terminal bound, clamped operand and
  // the saturated next count for one tick.
  logic [NUM_CH-1:0] cmd_hit;
  logic [WIDTH-1:0]  term  [NUM_CH];
  logic [WIDTH-1:0]  clamp [NUM_CH];
  logic [WIDTH-1:0]  step  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cmd_hit[g] = cmd_valid && (cmd_ch == CH_BITS'(g));
    assign term[g]    = dir[g] ? min_q[g] : max_q[g];
    // An inverted window (min > max) always clamps to min.
    assign clamp[g]   = ((min_q[g] > max_q[g]) || (cmd_data < min_q[g])) ? min_q[g] :
                        (cmd_data > max_q[g]) ? max_q[g] : cmd_data;
    // Compare before stepping so the counter can never wrap.
    assign step[g]    = dir[g] ?
                        ((cnt_q[g] > min_q[g]) ? cnt_q[g] - WIDTH'(1) : min_q[g]) :
                        ((cnt_q[g] < max_q[g]) ? cnt_q[g] + WIDTH'(1) : max_q[g]);

    assign count[g*WIDTH +: WIDTH] = cnt_q[g];
    assign busy[g] = (st_q[g] == ST_RUN);
    assign done[g] = (st_q[g] == ST_DONE);
  end

  assign expired = exp_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      min_d[i] = min_q[i];
      max_d[i] = max_q[i];
      st_d[i]  = st_q[i];
      exp_d[i] = 1'b0;
`ifdef SAT_TIMER_RELOAD_EN
      rld_d[i] = rld_q[i];
`endif
      if (cmd_hit[i]) begin
        case (cmd_op)
          OP_START: begin
            cnt_d[i] = clamp[i];
`ifdef SAT_TIMER_RELOAD_EN
            rld_d[i] = clamp[i];
`endif
            if (clamp[i] == term[i]) begin
              st_d[i]  = ST_DONE;
              exp_d[i] = 1'b1;
            end else begin
              st_d[i]  = ST_RUN;
            end
          end
          OP_SET_MIN: min_d[i] = cmd_data;
          OP_SET_MAX: max_d[i] = cmd_data;
          OP_CLEAR: begin
            cnt_d[i] = '0;
            st_d[i]  = ST_IDLE;
          end
          default: ;
        endcase
      end else if ((st_q[i] == ST_RUN) && tick) begin
`ifdef SAT_TIMER_RELOAD_EN
        // The terminal value is shown for one period slot, then the next
        // tick reloads; the channel never leaves RUN on its own.
        if (cnt_q[i] == term[i]) begin
          cnt_d[i] = rld_q[i];
        end else begin
          cnt_d[i] = step[i];
          if (step[i] == term[i]) exp_d[i] = 1'b1;
        end
`else
        cnt_d[i] = step[i];
        if (step[i] == term[i]) begin
          st_d[i]  = ST_DONE;
          exp_d[i] = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        min_q[i] <= '0;
        max_q[i] <= '1;
        st_q[i]  <= ST_IDLE;
`ifdef SAT_TIMER_RELOAD_EN
        rld_q[i] <= '0;
`endif
      end
      exp_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        min_q[i] <= min_d[i];
        max_q[i] <= max_d[i];
        st_q[i]  <= st_d[i];
`ifdef SAT_TIMER_RELOAD_EN
        rld_q[i] <= rld_d[i];
`endif
      end
      exp_q <= exp_d;
    end
  end

endmodule

// File: tb/tb_sat_timer_bank.sv
// Purpose : directed self-checking bench for sat_timer_bank (WIDTH=7, NUM_CH=4, CH_BITS=3).
// Latency : inputs driven and outputs sampled on the falling edge, one rising edge apart.
// Backpressure: none; the DUT accepts a command every cycle.
module tb_sat_timer_bank;

  localparam int W  = 7;
  localparam int NC = 4;
  localparam int CB = 3;

  logic           clk;
  logic           rst;
  logic           cmd_valid;
  logic [CB-1:0]  cmd_ch;
  logic [1:0]     cmd_op;
  logic [W-1:0]   cmd_data;
  logic           tick;
  logic [NC-1:0]  dir;
  logic [NC*W-1:0] count;
  logic [NC-1:0]  busy;
  logic [NC-1:0]  done;
  logic [NC-1:0]  expired;

  int n_cmp = 0;
  int n_err = 0;

  sat_timer_bank #(.WIDTH(W), .NUM_CH(NC), .CH_BITS(CB)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ch   (cmd_ch),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .tick     (tick),
    .dir      (dir),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cnt(input int ch);
    return int'(count[ch*W +: W]);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic cmd(input int ch, input logic [1:0] op, input int data);
    cmd_valid = 1'b1;
    cmd_ch    = CB'(ch);
    cmd_op    = op;
    cmd_data  = W'(data);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_data = '0;
    tick = 1'b0; dir = '0;
    cyc(2);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_expired", int'(expired), 0);
    rst = 1'b1;
    cyc(1);

`ifndef SAT_TIMER_RELOAD_EN
    // Down expiry on ch0: min=2, start 5.
    dir = 4'b0101;
    cmd(0, 2'b01, 2);
    check("setmin_keeps_count", cnt(0), 0);
    check("setmin_keeps_idle", int'(busy[0]), 0);
    cmd(0, 2'b00, 5);
    check("dn_start_count", cnt(0), 5);
    check("dn_start_busy", int'(busy[0]), 1);
    tick = 1'b1;
    cyc(1); check("dn_t1", cnt(0), 4);
    check("dn_t1_exp", int'(expired), 0);
    cyc(1); check("dn_t2", cnt(0), 3);
    cyc(1); check("dn_t3", cnt(0), 2);
    check("dn_t3_exp", int'(expired), 1);
    check("dn_t3_done", int'(done[0]), 1);
    check("dn_t3_busy", int'(busy[0]), 0);
    cyc(1); check("dn_hold", cnt(0), 2);
    check("dn_hold_exp", int'(expired), 0);
    tick = 1'b0;

    // Up saturation with clamp on ch1: max=10.
    cmd(1, 2'b10, 10);
    cmd(1, 2'b00, 20);
    check("up_clamp_count", cnt(1), 10);
    check("up_clamp_done", int'(done[1]), 1);
    check("up_clamp_exp", int'(expired), 2);
    cyc(1); check("up_clamp_exp_end", int'(expired), 0);
    cmd(1, 2'b00, 8);
    check("up_start8", cnt(1), 8);
    tick = 1'b1;
    cyc(1); check("up_t1", cnt(1), 9);
    check("up_t1_exp", int'(expired[1]), 0);
    cyc(1); check("up_t2", cnt(1), 10);
    check("up_t2_exp", int'(expired), 2);
    tick = 1'b0;

    // Collision: START to ch2 while tick advances ch0 and ch1.
    cmd(0, 2'b00, 6);
    cmd(1, 2'b00, 3);
    tick = 1'b1;
    cmd(2, 2'b00, 3);
    tick = 1'b0;
    check("col_ch2", cnt(2), 3);
    check("col_ch0", cnt(0), 5);
    check("col_ch1", cnt(1), 4);
    check("col_busy", int'(busy), 7);

    // CLEAR mid-run on ch3 (counting up).
    cmd(3, 2'b00, 6);
    check("clr_pre", cnt(3), 6);
    cmd(3, 2'b11, 0);
    check("clr_count", cnt(3), 0);
    check("clr_busy", int'(busy[3]), 0);
    check("clr_done", int'(done[3]), 0);
    check("clr_exp", int'(expired), 0);

    // Out-of-range channel indices change nothing.
    cmd(5, 2'b00, 9);
    cmd(4, 2'b11, 0);
    cmd(7, 2'b10, 1);
    check("inv_ch0", cnt(0), 5);
    check("inv_ch1", cnt(1), 4);
    check("inv_ch2", cnt(2), 3);
    check("inv_ch3", cnt(3), 0);
    check("inv_busy", int'(busy), 7);

    // Asynchronous reset in the middle of a running tick stream.
    tick = 1'b1;
    cyc(1);
    check("pre_rst_ch0", cnt(0), 4);
    check("pre_rst_ch1", cnt(1), 5);
    check("pre_rst_ch2", cnt(2), 2);
    #2 rst = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_exp", int'(expired), 0);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1);

    // Default max after reset saturates at 127 on an up channel.
    cmd(3, 2'b00, 125);
    tick = 1'b1;
    cyc(1); check("max_t1", cnt(3), 126);
    cyc(1); check("max_t2", cnt(3), 127);
    check("max_exp", int'(expired), 8);
    check("max_done", int'(done[3]), 1);
    cyc(1); check("max_hold", cnt(3), 127);
    tick = 1'b0;

    // Inverted window: min 9 > max 4 clamps to min; down channel is done at once.
    cmd(0, 2'b01, 9);
    cmd(0, 2'b10, 4);
    cmd(0, 2'b00, 6);
    check("inv_win_count", cnt(0), 9);
    check("inv_win_done", int'(done[0]), 1);
    check("inv_win_exp", int'(expired), 1);
`else
    // Periodic down channel: min=0, start 3.
    dir = 4'b0001;
    cmd(0, 2'b00, 3);
    check("rl_start", cnt(0), 3);
    tick = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cyc(1); check("rl_2", cnt(0), 2);
      check("rl_2_exp", int'(expired), 0);
      cyc(1); check("rl_1", cnt(0), 1);
      cyc(1); check("rl_0", cnt(0), 0);
      check("rl_0_exp", int'(expired), 1);
      check("rl_0_busy", int'(busy[0]), 1);
      check("rl_0_done", int'(done[0]), 0);
      cyc(1); check("rl_reload", cnt(0), 3);
      check("rl_reload_exp", int'(expired), 0);
      check("rl_reload_busy", int'(busy[0]), 1);
    end
    tick = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
